// File: rtl/instruction_memory_loader.sv
// Run-time writable instruction memory with byte-serial loader.
// IMEM_BOOT_PROGRAM_EN: power up with the built-in self-test program.
module instruction_memory_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   address,
  output logic [31:0]   instruction,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          load_end,
  output logic          cpu_hold,
  output logic [AW:0]   words_loaded,
  output logic          load_err,
  output logic          fetch_fault
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BYTES = 32'(4 * DEPTH);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [AW:0] words_q, words_d;
  logic        err_q, err_d;
  logic        fault_q, fault_d;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        addr_bad;

`ifdef IMEM_BOOT_PROGRAM_EN
  logic [31:0] mem_q [DEPTH] = '{
    0: 32'h00A0_0093, 1: 32'h0140_0113,
    2: 32'h0000_0193, 3: 32'h0020_81B3,
    4: 32'h0030_2023, 5: 32'h0010_0223,
    6: 32'h0020_1423, 7: 32'h1234_5237,
    8: 32'h0000_2283, 9: 32'h0040_0303,
    10: 32'h0080_1383, 11: 32'h0062_8433,
    12: 32'h0074_0433, 13: 32'h0080_2623,
    14: 32'h0000_006F, 15: NOP,
    default: NOP
  };
`else
  logic [31:0] mem_q [DEPTH] = '{default: NOP};
`endif

  assign load_ready   = (state_q == LOAD);
  assign cpu_hold     = (state_q == LOAD);
  assign words_loaded = words_q;
  assign load_err     = err_q;
  assign fetch_fault  = fault_q;

  assign addr_bad = (address[1:0] != 2'b00) || (address >= BYTES);

  // Zero-latency fetch; NOP while held or on a bad address
  always_comb begin
    instruction = NOP;
    if (!cpu_hold && !addr_bad)
      instruction = mem_q[address[AW+1:2]];
  end

  // Session control, byte assembly and sticky flags
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    ptr_d     = ptr_q;
    words_d   = words_q;
    err_d     = err_q;
    fault_d   = fault_q;
    mem_we    = 1'b0;
    mem_wdata = {load_data, asm_q};
    if (load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      asm_d   = '0;
      ptr_d   = '0;
      words_d = '0;
      err_d   = 1'b0;
      fault_d = 1'b0;
    end else if (state_q == LOAD) begin
      if (load_valid) begin
        if (ptr_q == FULL) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
          unique case (cnt_q)
            2'd0: asm_d[7:0]   = load_data;
            2'd1: asm_d[15:8]  = load_data;
            2'd2: asm_d[23:16] = load_data;
            2'd3: begin
              mem_we  = 1'b1;
              ptr_d   = ptr_q + 1'b1;
              words_d = words_q + 1'b1;
            end
          endcase
        end
      end
      if (load_end) begin
        state_d = IDLE;
        if (cnt_d != 2'd0) err_d = 1'b1;
        cnt_d = '0;
        asm_d = '0;
      end
    end else if (addr_bad) begin
      fault_d = 1'b1;
    end
  end

  // Control state; memory is deliberately outside reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      ptr_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ptr_q   <= ptr_d;
      words_q <= words_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  // Word write on acceptance of the fourth byte
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[ptr_q[AW-1:0]] <= mem_wdata;
  end

endmodule
